// File: rtl/swap_scheduler.sv
// Double-buffered frame scheduler: clears the back buffer, lets the GPU render into it, swaps on VGA vsync.
// Buffer writes appear one cycle after they are decided; the GPU is paced by gpu_start/gpu_done and has no stall path.
module swap_scheduler #(
  parameter int unsigned NUM_PIXELS  = 76800,
  parameter logic [3:0]  CLEAR_COLOR = 4'h0,
  parameter bit          CLEAR_EN    = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vga_vs,
  input  logic        gpu_done,
  input  logic [16:0] gpu_addr,
  input  logic [3:0]  gpu_data,
  input  logic        gpu_we,
  output logic        gpu_start,
  output logic [16:0] buf_addr,
  output logic [3:0]  buf_data,
  output logic        buf_we0,
  output logic        buf_we1,
  output logic        read_sel,
  output logic [7:0]  frame_count,
  output logic [7:0]  missed_frames,
  output logic        busy
);

  localparam logic [16:0] LAST_ADDR = 17'(NUM_PIXELS - 1);

  typedef enum logic [2:0] {
    S_CLEAR,
    S_START,
    S_RENDER,
    S_WAIT_SWAP,
    S_SWAP
  } state_t;

  state_t      state_q, state_d;
  logic        vs_s1, vs_s2, vs_hist;
  logic        vs_edge;
  logic        write_sel;
  logic [16:0] clr_cnt;
  logic        wr_vld;
  logic [16:0] wr_addr;
  logic [3:0]  wr_dat;
  logic        miss_inc;

  // vga_vs is asynchronous: two flops to resynchronize, a third to find the falling edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vs_s1   <= 1'b1;
      vs_s2   <= 1'b1;
      vs_hist <= 1'b1;
    end else begin
      vs_s1   <= vga_vs;
      vs_s2   <= vs_s1;
      vs_hist <= vs_s2;
    end
  end

  assign vs_edge = vs_hist & ~vs_s2;

  always_comb begin
    state_d  = state_q;
    wr_vld   = 1'b0;
    wr_addr  = clr_cnt;
    wr_dat   = CLEAR_COLOR;
    miss_inc = 1'b0;
    case (state_q)
      S_CLEAR: begin
        miss_inc = vs_edge;
        if (!CLEAR_EN) begin
          state_d = S_START;
        end else begin
          wr_vld = 1'b1;
          if (clr_cnt == LAST_ADDR) state_d = S_START;
        end
      end
      S_START: begin
        miss_inc = vs_edge;
        state_d  = S_RENDER;
      end
      S_RENDER: begin
        wr_vld  = gpu_we;
        wr_addr = gpu_addr;
        wr_dat  = gpu_data;
        if (gpu_done && vs_edge) state_d = S_SWAP;
        else if (gpu_done)       state_d = S_WAIT_SWAP;
        else                     miss_inc = vs_edge;
      end
      S_WAIT_SWAP: begin
        if (vs_edge) state_d = S_SWAP;
      end
      S_SWAP: begin
        state_d = CLEAR_EN ? S_CLEAR : S_START;
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_CLEAR;
      write_sel     <= 1'b0;
      clr_cnt       <= 17'd0;
      frame_count   <= 8'd0;
      missed_frames <= 8'd0;
    end else begin
      state_q <= state_d;
      if (state_q == S_SWAP) begin
        write_sel   <= ~write_sel;
        frame_count <= frame_count + 8'd1;
        clr_cnt     <= 17'd0;
      end else if (state_q == S_CLEAR && CLEAR_EN) begin
        clr_cnt <= (clr_cnt == LAST_ADDR) ? 17'd0 : clr_cnt + 17'd1;
      end
      if (miss_inc && missed_frames != 8'hFF) missed_frames <= missed_frames + 8'd1;
    end
  end

  // Write port is registered; the enable is steered to the back buffer only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_we0  <= 1'b0;
      buf_we1  <= 1'b0;
      buf_addr <= 17'd0;
      buf_data <= 4'h0;
    end else begin
      buf_we0 <= wr_vld & ~write_sel;
      buf_we1 <= wr_vld & write_sel;
      if (wr_vld) begin
        buf_addr <= wr_addr;
        buf_data <= wr_dat;
      end
    end
  end

  assign gpu_start = (state_q == S_START);
  assign busy      = (state_q != S_WAIT_SWAP);
  assign read_sel  = ~write_sel;

endmodule

// File: tb/tb_swap_scheduler.sv
// Bench for swap_scheduler: buffer writes checked through a scoreboard, control outputs checked directly.
module tb_swap_scheduler;

  typedef struct packed {
    logic        sel;
    logic [16:0] addr;
    logic [3:0]  data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vga_vs = 1'b1;
  logic        gpu_done = 1'b0;
  logic [16:0] gpu_addr = '0;
  logic [3:0]  gpu_data = '0;
  logic        gpu_we = 1'b0;
  logic        gpu_start, buf_we0, buf_we1, read_sel, busy;
  logic [16:0] buf_addr;
  logic [3:0]  buf_data;
  logic [7:0]  frame_count, missed_frames;

  logic        b_vs = 1'b1;
  logic        b_done = 1'b0;
  logic        b_gpu_start, b_we0, b_we1, b_read_sel, b_busy;
  logic [16:0] b_addr;
  logic [3:0]  b_data;
  logic [7:0]  b_fc, b_missed;
  logic        b_wrote = 1'b0;

  int  n_cmp = 0;
  int  n_fail = 0;
  wr_t sb[$];

  swap_scheduler #(.NUM_PIXELS(16), .CLEAR_COLOR(4'h0), .CLEAR_EN(1'b1)) dut (
    .clk(clk), .reset(rst_n), .vga_vs(vga_vs), .gpu_done(gpu_done),
    .gpu_addr(gpu_addr), .gpu_data(gpu_data), .gpu_we(gpu_we),
    .gpu_start(gpu_start), .buf_addr(buf_addr), .buf_data(buf_data),
    .buf_we0(buf_we0), .buf_we1(buf_we1), .read_sel(read_sel),
    .frame_count(frame_count), .missed_frames(missed_frames), .busy(busy)
  );

  swap_scheduler #(.NUM_PIXELS(16), .CLEAR_COLOR(4'h0), .CLEAR_EN(1'b0)) dut_nc (
    .clk(clk), .reset(rst_n), .vga_vs(b_vs), .gpu_done(b_done),
    .gpu_addr(17'd0), .gpu_data(4'h0), .gpu_we(1'b0),
    .gpu_start(b_gpu_start), .buf_addr(b_addr), .buf_data(b_data),
    .buf_we0(b_we0), .buf_we1(b_we1), .read_sel(b_read_sel),
    .frame_count(b_fc), .missed_frames(b_missed), .busy(b_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (b_we0 || b_we1) b_wrote = 1'b1;
    if (buf_we0 && buf_we1) begin
      n_cmp++;
      n_fail++;
      $display("FAIL both_we: buf_we0 and buf_we1 high together");
    end else if (buf_we0 || buf_we1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: sel=%0d addr=%0d data=0x%0h, expected no write",
                 buf_we1, buf_addr, buf_data);
      end else begin
        wr_t e;
        e = sb.pop_front();
        if (buf_we1 !== e.sel || buf_addr !== e.addr || buf_data !== e.data) begin
          n_fail++;
          $display("FAIL write: got sel=%0d addr=%0d data=0x%0h, expected sel=%0d addr=%0d data=0x%0h",
                   buf_we1, buf_addr, buf_data, e.sel, e.addr, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_clear(input logic sel);
    for (int i = 0; i < 16; i++) sb.push_back({sel, 17'(i), 4'h0});
  endtask

  task automatic wait_start(input int exp_n, input string name);
    int n;
    n = 0;
    while (gpu_start !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    chk(name, n, exp_n);
  endtask

  task automatic vs_pulse();
    vga_vs = 1'b0;
    repeat (3) tick();
    vga_vs = 1'b1;
    repeat (3) tick();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_gpu_start"}, gpu_start, 0);
    chk({tag, "_we"}, {buf_we0, buf_we1}, 0);
    chk({tag, "_addr"}, buf_addr, 0);
    chk({tag, "_data"}, buf_data, 0);
    chk({tag, "_read_sel"}, read_sel, 1);
    chk({tag, "_frame_count"}, frame_count, 0);
    chk({tag, "_missed"}, missed_frames, 0);
    chk({tag, "_busy"}, busy, 1);
  endtask

  initial begin
    int found;
    repeat (3) tick();
    chk_reset_vals("rst");
    push_clear(1'b0);
    rst_n = 1'b1;
    tick();
    chk("nc_start_after_reset", b_gpu_start, 1);
    wait_start(15, "clear0_len");
    tick();
    chk("start_pulse_width", gpu_start, 0);

    // Render writes to buffer 0 with one-cycle latency.
    gpu_we = 1'b1; gpu_addr = 17'd5; gpu_data = 4'hA;
    sb.push_back({1'b0, 17'd5, 4'hA});
    tick();
    chk("render_lat_we0", buf_we0, 1);
    chk("render_lat_addr", buf_addr, 5);
    gpu_addr = 17'd3; gpu_data = 4'h7;
    sb.push_back({1'b0, 17'd3, 4'h7});
    tick();
    gpu_we = 1'b0; gpu_done = 1'b1;
    tick();
    gpu_done = 1'b0;
    chk("wait_busy", busy, 0);
    gpu_we = 1'b1; gpu_addr = 17'd5; gpu_data = 4'hA;
    tick();
    tick();
    chk("wait_no_write", {buf_we0, buf_we1}, 0);
    gpu_we = 1'b0;

    // Vsync falling edge: swap lands four cycles later.
    vga_vs = 1'b0;
    push_clear(1'b1);
    repeat (3) tick();
    chk("read_sel_pre_swap", read_sel, 1);
    tick();
    chk("read_sel_swap1", read_sel, 0);
    chk("frame_count_swap1", frame_count, 1);
    vga_vs = 1'b1;
    wait_start(16, "clear1_len");
    tick();
    gpu_we = 1'b1; gpu_addr = 17'd9; gpu_data = 4'hC;
    sb.push_back({1'b1, 17'd9, 4'hC});
    tick();
    gpu_we = 1'b0;

    repeat (3) vs_pulse();
    chk("missed_3", missed_frames, 3);
    chk("read_sel_after_missed", read_sel, 0);
    chk("frame_count_after_missed", frame_count, 1);

    // Vsync edge and gpu_done in the same RENDER cycle.
    vga_vs = 1'b0;
    tick();
    tick();
    gpu_done = 1'b1;
    push_clear(1'b0);
    tick();
    gpu_done = 1'b0;
    vga_vs = 1'b1;
    chk("coinc_swap_busy", busy, 1);
    tick();
    chk("coinc_read_sel", read_sel, 1);
    chk("coinc_frame_count", frame_count, 2);
    chk("coinc_missed", missed_frames, 3);
    wait_start(16, "clear2_len");
    tick();

    repeat (252) vs_pulse();
    chk("missed_255", missed_frames, 255);
    repeat (5) vs_pulse();
    chk("missed_saturate", missed_frames, 255);

    // Swap to buffer 1, then reset in the middle of its clear.
    gpu_done = 1'b1;
    tick();
    gpu_done = 1'b0;
    vga_vs = 1'b0;
    push_clear(1'b1);
    repeat (4) tick();
    vga_vs = 1'b1;
    chk("read_sel_swap3", read_sel, 0);
    chk("frame_count_swap3", frame_count, 3);
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      if (buf_we1 === 1'b1 && buf_addr === 17'd9) found = 1;
      else tick();
    end
    chk("reached_addr9", found, 1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    sb.delete();
    push_clear(1'b0);
    tick();
    rst_n = 1'b1;
    wait_start(16, "clear_after_rst");
    tick();

    // CLEAR_EN=0 instance: START directly follows SWAP.
    b_done = 1'b1;
    tick();
    b_done = 1'b0;
    chk("nc_wait_busy", b_busy, 0);
    b_vs = 1'b0;
    repeat (3) tick();
    chk("nc_swap_no_start", b_gpu_start, 0);
    tick();
    chk("nc_start_after_swap", b_gpu_start, 1);
    chk("nc_read_sel", b_read_sel, 0);
    chk("nc_frame_count", b_fc, 1);
    tick();
    chk("nc_start_width", b_gpu_start, 0);
    b_vs = 1'b1;
    tick();
    chk("nc_no_writes", b_wrote, 0);
    chk("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/swap_scheduler.md
SWAP_SCHEDULER -- requirements
Module: swap_scheduler

Interface
REQ-001 Parameter NUM_PIXELS, default 76800, pixels per frame buffer (320x240); SHALL be at most 2^17.
REQ-002 Parameter CLEAR_COLOR, default 4'h0, pixel value written during buffer clear.
REQ-003 Parameter CLEAR_EN, default 1, 1 = clear back buffer before each render, 0 = skip clear.
REQ-004 clk  in  1  single clock (GPU clock domain); all logic on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 vga_vs  in  1  raw active-low VGA vertical sync, asynchronous to clk.
REQ-007 gpu_done  in  1  level; GPU finished rendering current frame.
REQ-008 gpu_addr  in  17  GPU pixel write address (already translated).
REQ-009 gpu_data  in  4  GPU pixel value.
REQ-010 gpu_we  in  1  GPU pixel write strobe.
REQ-011 gpu_start  out  1  one-cycle pulse, start rendering next frame.
REQ-012 buf_addr  out  17  frame buffer write address.
REQ-013 buf_data  out  4  frame buffer write data.
REQ-014 buf_we0, buf_we1  out  1 each  write enables, buffer 0 / buffer 1.
REQ-015 read_sel  out  1  buffer the VGA side reads (0 = buffer0, 1 = buffer1).
REQ-016 frame_count  out  8  completed swaps, wraps 255 -> 0.
REQ-017 missed_frames  out  8  VS edges with no frame ready, saturates at 255.
REQ-018 busy  out  1  high in every state except WAIT_SWAP.

Function
REQ-019 vga_vs SHALL pass a 2-flop synchronizer plus one history flop; vs_edge = one-cycle pulse on synchronized 1->0 transition, 3 clk after the async falling edge.
REQ-020 Internal write_sel SHALL select the back buffer; read_sel SHALL always equal !write_sel.
REQ-021 FSM states: CLEAR, START, RENDER, WAIT_SWAP, SWAP.
REQ-022 CLEAR: clear counter steps 0..NUM_PIXELS-1, one write per cycle, data CLEAR_COLOR, to back buffer; after writing NUM_PIXELS-1 -> START (exactly NUM_PIXELS cycles in CLEAR).
REQ-023 With CLEAR_EN=0, every transition into CLEAR SHALL go to START instead.
REQ-024 START: one cycle, gpu_start high, -> RENDER; gpu_start low in all other states.
REQ-025 RENDER: gpu_addr/gpu_data/gpu_we forwarded to back buffer; gpu_done=1 -> WAIT_SWAP.
REQ-026 gpu_we outside RENDER SHALL be ignored (no buffer write).
REQ-027 WAIT_SWAP: no writes; vs_edge -> SWAP.
REQ-028 SWAP: one cycle; write_sel toggles, frame_count increments, clear counter reset to 0, -> CLEAR.
REQ-029 vs_edge in CLEAR, START or RENDER (without simultaneous gpu_done) SHALL increment missed_frames (saturating), no state change.
REQ-030 vs_edge and gpu_done in same RENDER cycle SHALL go directly to SWAP, missed_frames unchanged.
REQ-031 buf_addr, buf_data, buf_we0, buf_we1 SHALL be registered: a write decided in cycle N appears on outputs in cycle N+1.
REQ-032 Exactly one of buf_we0/buf_we1 SHALL be high per cycle, or neither; never both.
REQ-033 read_sel and frame_count SHALL update in the cycle after SWAP, simultaneously.

Reset
REQ-034 reset low: state CLEAR, write_sel 0, read_sel 1, clear counter 0, synchronizer flops 1, gpu_start 0, buf_we0/1 0, buf_addr 0, buf_data 0, frame_count 0, missed_frames 0, busy 1.
REQ-035 Reset asserted mid-operation SHALL abort any clear/render immediately; after release, operation restarts with CLEAR of buffer 0.

Verification (NUM_PIXELS=16 unless noted)
REQ-036 Release reset -> buf_we0 high 16 cycles, buf_addr 0..15, buf_data 4'h0, then one-cycle gpu_start.
REQ-037 RENDER, gpu_we=1, gpu_addr=5, gpu_data=4'hA -> next cycle buf_we0=1, buf_addr=5, buf_data=4'hA; same stimulus in WAIT_SWAP -> no write.
REQ-038 gpu_done=1, then vga_vs falls -> SWAP 4 cycles later; read_sel 1->0, frame_count 0->1, next clear on buf_we1.
REQ-039 Three vga_vs falling edges during RENDER with gpu_done=0 -> missed_frames=3, read_sel unchanged; 260 edges -> saturates 255.
REQ-040 vs_edge coincident with gpu_done in RENDER -> SWAP next cycle, missed_frames unchanged; CLEAR_EN=0 -> START immediately follows SWAP.
REQ-041 reset pulsed low during CLEAR at address 9 -> all outputs at reset values asynchronously; restart clear at address 0 on buffer 0.
